// File: rtl/hack_memory_responder.sv
// Hack CPU data-memory responder: RAM, screen shadow with a write-forwarding
// FIFO toward the display, and the keyboard register, behind one registered read port.
module hack_memory_responder #(
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_WORDS = 8192,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        i_CLK,
    input  logic        i_RESET_n,
    input  logic [15:0] i_Address,
    input  logic [15:0] i_Data,
    input  logic        i_Write,
    output logic [15:0] o_Data,
    output logic        o_Scr_Valid,
    output logic [12:0] o_Scr_Addr,
    output logic [15:0] o_Scr_Data,
    input  logic        i_Scr_Ready,
    input  logic [15:0] i_Key_Code,
    input  logic        i_Key_Strobe,
    output logic        o_Scr_Full,
    output logic        o_Overflow
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [15:0] SCREEN_BASE = 16'h4000;
    localparam logic [15:0] KBD_ADDR    = 16'h6000;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [15:0] ram    [RAM_WORDS];
    logic [15:0] shadow [SCREEN_WORDS];

    logic [15:0] fifo_data [FIFO_DEPTH];
    logic [12:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic [15:0] key_reg;
    logic [15:0] rd_word;

    logic              ram_sel;
    logic              scr_sel;
    logic              kbd_sel;
    logic [12:0]       scr_off;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;

    logic ram_we;
    logic scr_we;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign ram_sel = (i_Address < SCREEN_BASE);
    assign scr_sel = (i_Address >= SCREEN_BASE) && (i_Address < KBD_ADDR);
    assign kbd_sel = (i_Address == KBD_ADDR);

    assign scr_off = 13'(i_Address - SCREEN_BASE);
    assign ram_idx = i_Address[RAM_AW-1:0];
    assign scr_idx = scr_off[SCR_AW-1:0];

    assign ram_we = i_Write && ram_sel;
    assign scr_we = i_Write && scr_sel;

    // ------------------------------------------------------------------
    // Storage arrays are deliberately left out of reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (ram_we) begin
            ram[ram_idx] <= i_Data;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (scr_we) begin
            shadow[scr_idx] <= i_Data;
        end
    end

    // Read-first: the mux sees pre-edge contents, so a same-cycle write shows next cycle
    always_comb begin
        rd_word = '0;
        if (ram_sel) begin
            rd_word = ram[ram_idx];
        end else if (scr_sel) begin
            rd_word = shadow[scr_idx];
        end else if (kbd_sel) begin
            rd_word = key_reg;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            o_Data  <= '0;
            key_reg <= '0;
        end else begin
            o_Data <= rd_word;
            if (i_Key_Strobe) begin
                key_reg <= i_Key_Code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Screen write FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);

    assign pop  = !fifo_empty && i_Scr_Ready;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the push
    assign push = scr_we && (!fifo_full || pop);
    assign drop = scr_we && fifo_full && !pop;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= i_Data;
                fifo_addr[wr_ptr] <= scr_off;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (drop) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    assign o_Scr_Valid = !fifo_empty;
    assign o_Scr_Full  = fifo_full;
    assign o_Scr_Addr  = fifo_addr[rd_ptr];
    assign o_Scr_Data  = fifo_data[rd_ptr];

endmodule

// File: tb/tb_hack_memory_responder.sv
// Self-checking bench for hack_memory_responder: directed scenarios plus a
// randomized run compared against a queue/array reference model.
module tb_hack_memory_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] rdata;
    logic        scr_valid;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ready;
    logic [15:0] key_code;
    logic        key_strobe;
    logic        scr_full;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] key_m;
    bit          ovf_m;
    logic [28:0] q_m [$];
    logic [15:0] exp_data;
    bit          exp_known;

    always #5 clk = ~clk;

    hack_memory_responder #(
        .RAM_WORDS   (16384),
        .SCREEN_WORDS(8192),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_CLK       (clk),
        .i_RESET_n   (rst_n),
        .i_Address   (addr),
        .i_Data      (wdata),
        .i_Write     (wr),
        .o_Data      (rdata),
        .o_Scr_Valid (scr_valid),
        .o_Scr_Addr  (scr_addr),
        .o_Scr_Data  (scr_data),
        .i_Scr_Ready (scr_ready),
        .i_Key_Code  (key_code),
        .i_Key_Strobe(key_strobe),
        .o_Scr_Full  (scr_full),
        .o_Overflow  (overflow)
    );

    task automatic model_reset();
        q_m.delete();
        ovf_m     = 1'b0;
        key_m     = 16'h0;
        exp_data  = 16'h0;
        exp_known = 1'b1;
    endtask

    // Drive one cycle of stimulus and advance the model; returns #1 after the edge
    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                        input logic rdy, input logic [15:0] kc, input logic ks);
        int off;
        @(negedge clk);
        addr = a; wdata = d; wr = w; scr_ready = rdy; key_code = kc; key_strobe = ks;
        off = int'(a) - 16'h4000;
        exp_known = 1'b1;
        if (a < 16'h4000) begin
            if (ram_m.exists(int'(a))) exp_data = ram_m[int'(a)];
            else exp_known = 1'b0;
        end else if (a < 16'h6000) begin
            if (scr_m.exists(off)) exp_data = scr_m[off];
            else exp_known = 1'b0;
        end else if (a == 16'h6000) begin
            exp_data = key_m;
        end else begin
            exp_data = 16'h0;
        end
        if (q_m.size() != 0 && rdy) void'(q_m.pop_front());
        if (w) begin
            if (a < 16'h4000) begin
                ram_m[int'(a)] = d;
            end else if (a < 16'h6000) begin
                scr_m[off] = d;
                if (q_m.size() < DEPTH) q_m.push_back({13'(off), d});
                else ovf_m = 1'b1;
            end
        end
        if (ks) key_m = kc;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; wr = 1'b0; scr_ready = 1'b0; key_strobe = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr = '0; wdata = '0; wr = 1'b0; scr_ready = 1'b0;
        key_code = '0; key_strobe = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", rdata); end
        n_checks++; if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", scr_valid); end
        n_checks++; if (scr_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", scr_full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_checks++; if ({scr_addr, scr_data} !== 29'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", scr_addr, scr_data); end
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_key: got %h want 0000", rdata); end
    endtask

    task automatic test_ram_rw();
        step(16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL ram_read: got %h want 1234", rdata); end
        step(16'h0010, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL ram_read_first: got %h want 1234", rdata); end
        step(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL ram_new: got %h want beef", rdata); end
        step(16'h3FFF, 16'h7A7A, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h3FFF, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h7A7A) begin n_fail++; $display("FAIL ram_top: got %h want 7a7a", rdata); end
        n_checks++; if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL ram_no_push: got %b want 0", scr_valid); end
    endtask

    task automatic test_screen_single();
        step(16'h4005, 16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++; if (scr_valid !== 1'b1) begin n_fail++; $display("FAIL scr_valid: got %b want 1", scr_valid); end
        n_checks++; if (scr_addr !== 13'h0005) begin n_fail++; $display("FAIL scr_addr: got %h want 0005", scr_addr); end
        n_checks++; if (scr_data !== 16'hFFFF) begin n_fail++; $display("FAIL scr_data: got %h want ffff", scr_data); end
        step(16'h4005, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'hFFFF) begin n_fail++; $display("FAIL scr_shadow: got %h want ffff", rdata); end
        n_checks++; if ({scr_valid, scr_addr, scr_data} !== {1'b1, 13'h0005, 16'hFFFF}) begin
            n_fail++; $display("FAIL scr_stable: got %b/%h/%h want 1/0005/ffff", scr_valid, scr_addr, scr_data); end
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0, 1'b0);
        n_checks++; if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL scr_popped: got %b want 0", scr_valid); end
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0, 1'b0);
        n_checks++; if ({scr_valid, scr_full} !== 2'b00) begin n_fail++; $display("FAIL scr_empty_ready: got %b want 00", {scr_valid, scr_full}); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step(16'h4000 + 16'(i), 16'(i + 1), 1'b1, 1'b0, 16'h0, 1'b0);
            if (i == 3) begin
                n_checks++; if (scr_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full4: got %b want 1", scr_full); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({scr_valid, scr_addr, scr_data} !== {1'b1, 13'(i), 16'(i + 1)}) begin
                n_fail++; $display("FAIL ovf_drain%0d: got %b/%h/%h want 1/%h/%h", i, scr_valid, scr_addr, scr_data, 13'(i), 16'(i + 1)); end
            step(16'h4004, 16'h0000, 1'b0, 1'b1, 16'h0, 1'b0);
            if (i == 0) begin
                n_checks++; if (rdata !== 16'h0005) begin n_fail++; $display("FAIL ovf_shadow5: got %h want 0005", rdata); end
            end
        end
        n_checks++; if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", scr_valid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        pulse_reset();
        #1;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] drain_exp [4];
        drain_exp[0] = 16'h00A3; drain_exp[1] = 16'h00B0; drain_exp[2] = 16'h00B1; drain_exp[3] = 16'h00B2;
        for (int i = 0; i < 4; i++) step(16'h4010 + 16'(i), 16'h00A0 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step(16'h4020 + 16'(j), 16'h00B0 + 16'(j), 1'b1, 1'b1, 16'h0, 1'b0);
            n_checks++; if ({scr_full, overflow} !== 2'b10) begin
                n_fail++; $display("FAIL pp_full%0d: got full/ovf %b want 10", j, {scr_full, overflow}); end
            n_checks++; if (scr_data !== 16'h00A1 + 16'(j)) begin
                n_fail++; $display("FAIL pp_head%0d: got %h want %h", j, scr_data, 16'h00A1 + 16'(j)); end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (scr_data !== drain_exp[i]) begin
                n_fail++; $display("FAIL pp_drain%0d: got %h want %h", i, scr_data, drain_exp[i]); end
            step(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0, 1'b0);
        end
        n_checks++; if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %b want 0", scr_valid); end
    endtask

    task automatic test_keyboard();
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0041, 1'b1);
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL kbd_same_cycle: got %h want 0000", rdata); end
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h0041) begin n_fail++; $display("FAIL kbd_read: got %h want 0041", rdata); end
        step(16'h6000, 16'h9999, 1'b1, 1'b0, 16'h0, 1'b0);
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h0041) begin n_fail++; $display("FAIL kbd_write_ignored: got %h want 0041", rdata); end
        step(16'h7000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL kbd_invalid: got %h want 0000", rdata); end
        step(16'h6001, 16'h5555, 1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++; if ({rdata, scr_valid} !== 17'h0) begin n_fail++; $display("FAIL kbd_6001: got %h/%b want 0000/0", rdata, scr_valid); end
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b1);
        n_checks++; if (rdata !== 16'h0041) begin n_fail++; $display("FAIL kbd_prev: got %h want 0041", rdata); end
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL kbd_zero: got %h want 0000", rdata); end
    endtask

    task automatic test_reset_midburst();
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h1111, 1'b1);
        for (int i = 0; i < 3; i++) step(16'h4100 + 16'(i), 16'hC000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
        n_checks++; if (scr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_before: got %b want 1", scr_valid); end
        #2;
        rst_n = 1'b0; wr = 1'b0; scr_ready = 1'b0; key_strobe = 1'b0;
        #1;
        model_reset();
        n_checks++; if ({scr_valid, scr_full, overflow} !== 3'b000) begin
            n_fail++; $display("FAIL mid_flush: got %b want 000", {scr_valid, scr_full, overflow}); end
        n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0000", rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h4100, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'hC000) begin n_fail++; $display("FAIL mid_shadow_kept: got %h want c000", rdata); end
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL mid_key_cleared: got %h want 0000", rdata); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        int r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: a = 16'($urandom_range(0, 31));
                3:       a = 16'h3FE0 + 16'($urandom_range(0, 31));
                4, 5:    a = 16'h4000 + 16'($urandom_range(0, 15));
                6:       a = 16'h5FF0 + 16'($urandom_range(0, 15));
                7:       a = 16'h6000;
                8:       a = 16'h6001 + 16'($urandom_range(0, 15));
                default: a = 16'($urandom_range(16'h6001, 16'hFFFF));
            endcase
            step(a, 16'($urandom()), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 16'($urandom()), ($urandom_range(0, 7) == 0));
            if (exp_known) begin
                n_checks++; if (rdata !== exp_data) begin
                    n_fail++; $display("FAIL rnd_data[%0d] addr %h: got %h want %h", n, a, rdata, exp_data); end
            end
            n_checks++; if (scr_valid !== (q_m.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, scr_valid, q_m.size() != 0); end
            n_checks++; if (scr_full !== (q_m.size() == DEPTH)) begin
                n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", n, scr_full, q_m.size() == DEPTH); end
            n_checks++; if (overflow !== ovf_m) begin
                n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, overflow, ovf_m); end
            if (q_m.size() != 0) begin
                n_checks++; if ({scr_addr, scr_data} !== q_m[0]) begin
                    n_fail++; $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", n, scr_addr, scr_data, q_m[0][28:16], q_m[0][15:0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_screen_single();
        test_overflow();
        test_full_push_pop();
        test_keyboard();
        test_reset_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
